// File: rtl/regfile_write_bank_pkg.sv
// Shared constants and FSM encoding for the register-file write bank.
// Imported by the bank top and its address decoder.
package regfile_write_bank_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;

    localparam logic [ADDR_W-1:0] CNT_LAST = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/regfile_write_bank_decoder_5to32.sv
// 5-to-32 one-hot decoder with enable.
// Shared by the write path and the clear sequencer.
module decoder_5to32
    import regfile_write_bank_pkg::*;
(
    input  logic                en,
    input  logic [ADDR_W-1:0]   in,
    output logic [NUM_REGS-1:0] out
);

    // One bit set at position 'in' when enabled, otherwise all zero
    always_comb begin
        out = '0;
        if (en) out[in] = 1'b1;
    end

endmodule

// File: rtl/regfile_write_bank.sv
// Write side of the 32-entry register file with a sequenced
// one-entry-per-cycle clear engine and a valid/ready write port.
module regfile_write_bank
    import regfile_write_bank_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      clr_req,
    output logic                      busy,
    output logic                      clr_done,
    output logic [NUM_REGS-1:0]       wr_onehot,
    output logic [NUM_REGS*WIDTH-1:0] q_flat
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_nxt;
    logic                w_ready_st;
    logic                w_fire;
    logic                w_clr_en;
    logic [NUM_REGS-1:0] w_clr_onehot;
    logic [WIDTH-1:0]    r_regs [NUM_REGS];

    // Reset holds the port closed even before the state register settles
    assign wr_ready = w_ready_st & ~reset;
    assign w_fire   = wr_valid & wr_ready;
    assign w_clr_en = (r_state == S_CLEAR);

    decoder_5to32 u_wr_dec (
        .en  (w_fire),
        .in  (wr_addr),
        .out (wr_onehot)
    );

    decoder_5to32 u_clr_dec (
        .en  (w_clr_en),
        .in  (r_cnt),
        .out (w_clr_onehot)
    );

    // State and clear-counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic and Moore outputs
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready_st  = 1'b1;
        busy        = 1'b0;
        clr_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                w_ready_st = 1'b0;
                busy       = 1'b1;
                if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
                else                   w_cnt_nxt   = r_cnt + 1'b1;
            end
            S_DONE: begin
                clr_done    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_ready_st  = 1'b0;
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Storage: clear wins over write; entry 0 optionally pinned to zero
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reset)                  r_regs[i] <= '0;
            else if (ZERO_REG && i == 0) r_regs[i] <= '0;
            else if (w_clr_onehot[i])   r_regs[i] <= '0;
            else if (wr_onehot[i])      r_regs[i] <= wr_data;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign q_flat[g*WIDTH +: WIDTH] = r_regs[g];
    end

endmodule

// File: tb/tb_regfile_write_bank.sv
// Directed self-checking bench for regfile_write_bank.
// Two instances share stimulus: ZERO_REG=1 (a) and ZERO_REG=0 (b).
module tb_regfile_write_bank;

    logic          clock = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic          clr_req;

    logic          rdy_a, busy_a, done_a;
    logic [31:0]   oh_a;
    logic [1023:0] q_a;
    logic          rdy_b, busy_b, done_b;
    logic [31:0]   oh_b;
    logic [1023:0] q_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    regfile_write_bank #(.WIDTH(32), .ZERO_REG(1'b1)) u_dut_a (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(rdy_a),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .busy(busy_a), .clr_done(done_a),
        .wr_onehot(oh_a), .q_flat(q_a)
    );

    regfile_write_bank #(.WIDTH(32), .ZERO_REG(1'b0)) u_dut_b (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(rdy_b),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .busy(busy_b), .clr_done(done_b),
        .wr_onehot(oh_b), .q_flat(q_b)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ent(input logic [1023:0] q,
                                        input int i);
        return q[i*32 +: 32];
    endfunction

    function automatic int nz(input logic [1023:0] q);
        int n = 0;
        for (int i = 0; i < 32; i++)
            if (q[i*32 +: 32] != 32'd0) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fill(input logic [31:0] base);
        for (int i = 0; i < 32; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 5'(i);
            wr_data  = base + 32'(i);
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
    endtask

    initial begin
        int busy_n, done_n, rdy_bad, fire_bad, found;
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        clr_req  = 1'b0;
        tick();
        tick();
        chk("rst_ready", rdy_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", rdy_a, 1);
        chk("rst_zero", nz(q_a) + nz(q_b), 0);

        // Basic write, no bypass
        wr_valid = 1'b1;
        wr_addr  = 5'd5;
        wr_data  = 32'hDEADBEEF;
        #1;
        chk("wr_onehot5", oh_a, 32'h0000_0020);
        chk("no_bypass", ent(q_a, 5), 0);
        tick();
        wr_valid = 1'b0;
        #1;
        chk("wr_e5", ent(q_a, 5), 32'hDEADBEEF);
        chk("wr_only_one", nz(q_a), 1);

        // Entry 0 handling
        wr_valid = 1'b1;
        wr_addr  = 5'd0;
        wr_data  = 32'hFFFFFFFF;
        #1;
        chk("z_ready", rdy_a, 1);
        chk("z_onehot", oh_a, 32'h1);
        tick();
        wr_valid = 1'b0;
        #1;
        chk("z_a_e0", ent(q_a, 0), 0);
        chk("z_b_e0", ent(q_b, 0), 32'hFFFFFFFF);

        // Full clear of a filled bank
        fill(32'd1);
        chk("fill_e31", ent(q_a, 31), 32);
        chk("fill_b_e0", ent(q_b, 0), 1);
        pulse_clr();
        busy_n = 0; done_n = 0; rdy_bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy_a) busy_n++;
            if (done_a) done_n++;
            if (busy_a && rdy_a) rdy_bad++;
            tick();
        end
        chk("clr_busy_cycles", busy_n, 32);
        chk("clr_done_pulses", done_n, 1);
        chk("clr_ready_low", rdy_bad, 0);
        chk("clr_all_zero", nz(q_a) + nz(q_b), 0);

        // Write stalls during clear, fires in DONE
        pulse_clr();
        wr_valid = 1'b1;
        wr_addr  = 5'd7;
        wr_data  = 32'h12345678;
        fire_bad = 0; found = 0;
        #1;
        for (int k = 0; k < 40 && found == 0; k++) begin
            if (busy_a && oh_a != 0) fire_bad++;
            if (done_a) begin
                found = 1;
                chk("stall_fire_done", oh_a, 32'h80);
                chk("stall_ready_done", rdy_a, 1);
            end else begin
                tick();
            end
        end
        chk("stall_seen_done", found, 1);
        chk("stall_no_fire", fire_bad, 0);
        tick();
        wr_valid = 1'b0;
        #1;
        chk("stall_e7", ent(q_a, 7), 32'h12345678);
        chk("stall_only_one", nz(q_a), 1);

        // Write and clear request in the same cycle
        wr_valid = 1'b1;
        wr_addr  = 5'd3;
        wr_data  = 32'hA5A5A5A5;
        clr_req  = 1'b1;
        #1;
        chk("sim_onehot", oh_a, 32'h8);
        tick();
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        #1;
        chk("sim_e3_kept", ent(q_a, 3), 32'hA5A5A5A5);
        chk("sim_busy", busy_a, 1);
        tick(); tick(); tick();
        chk("sim_e3_at3", ent(q_a, 3), 32'hA5A5A5A5);
        tick();
        chk("sim_e3_clr", ent(q_a, 3), 0);
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            if (done_a) found = 1;
            tick();
        end
        chk("sim_clr_end", found, 1);
        chk("sim_all_zero", nz(q_a), 0);

        // Reset in the middle of a clear
        fill(32'd100);
        pulse_clr();
        repeat (10) tick();
        chk("mid_nz_a", nz(q_a), 22);
        chk("mid_nz_b", nz(q_b), 22);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", rdy_a, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_zero", nz(q_a) + nz(q_b), 0);
        chk("mid_busy", busy_a, 0);
        chk("mid_ready", rdy_a, 1);
        done_n = 0; busy_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_a || done_b) done_n++;
            if (busy_a || busy_b) busy_n++;
            tick();
        end
        chk("mid_no_done", done_n, 0);
        chk("mid_no_busy", busy_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
